// File: rtl/queue_packet_reader_pkg.sv
// Shared definitions for the variable-length queue read side.
//   LEN_W_DEFAULT : default width of a length entry (stored value is beats-1)
//   STATS_W       : width of the optional packet/beat statistics counters
//   state_t       : reader FSM states
//   len_t         : length entry at the default width
package queue_pkg;

  localparam int LEN_W_DEFAULT = 11;
  localparam int STATS_W       = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEN    = 2'd1,
    STREAM = 2'd2
  } state_t;

  typedef logic [LEN_W_DEFAULT-1:0] len_t;

endpackage

// File: rtl/queue_packet_reader_if.sv
// Read-port and output-stream bundle of the queue packet reader.
//   len_rd_en / len_rd_data / len_empty : length FIFO read port (data one cycle after pop)
//   dat_rd_en / dat_rd_data / dat_empty : data FIFO read port (data one cycle after pop)
//   o_data / o_valid / o_first / o_last / i_ready : framed valid/ready beat stream
// master = the reader, slave = the FIFOs plus the downstream consumer.
interface queue_packet_reader_if
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = LEN_W_DEFAULT
);

  logic                  len_rd_en;
  logic [LEN_W-1:0]      len_rd_data;
  logic                  len_empty;
  logic                  dat_rd_en;
  logic [DATA_WIDTH-1:0] dat_rd_data;
  logic                  dat_empty;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_first;
  logic                  o_last;
  logic                  i_ready;

  modport master (
    output len_rd_en, input len_rd_data, input len_empty,
    output dat_rd_en, input dat_rd_data, input dat_empty,
    output o_data, output o_valid, output o_first, output o_last,
    input  i_ready
  );

  modport slave (
    input  len_rd_en, output len_rd_data, output len_empty,
    input  dat_rd_en, output dat_rd_data, output dat_empty,
    input  o_data, input o_valid, input o_first, input o_last,
    output i_ready
  );

endinterface

// File: rtl/queue_packet_reader_skid.sv
// Two-entry valid/ready skid buffer. The head register drives the output
// directly; the tail absorbs one extra beat while the head is stalled.
//   clk, i_reset        : clock, synchronous active-high reset
//   in_valid/in_payload : write side (no ready; the producer limits itself via count)
//   out_valid/out_payload/out_ready : read side
//   count               : number of occupied entries (0..2)
module queue_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_payload,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic             head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic             fire;

  assign fire        = head_vld_q && out_ready;
  assign out_valid   = head_vld_q;
  assign out_payload = head_q;
  assign count       = {1'b0, head_vld_q} + {1'b0, tail_vld_q};

  // On a transfer the tail (if any) moves up to the head and the incoming
  // beat refills behind it; otherwise the incoming beat fills the first
  // free slot. The producer never writes when both slots are occupied.
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    if (fire) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        head_vld_d = 1'b1;
        tail_vld_d = in_valid;
        if (in_valid) tail_d = in_payload;
      end else begin
        head_vld_d = in_valid;
        if (in_valid) head_d = in_payload;
      end
    end else if (in_valid) begin
      if (!head_vld_q) begin
        head_d     = in_payload;
        head_vld_d = 1'b1;
      end else if (!tail_vld_q) begin
        tail_d     = in_payload;
        tail_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      tail_q     <= '0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      tail_q     <= tail_d;
      tail_vld_q <= tail_vld_d;
    end
  end

endmodule

// File: rtl/queue_packet_reader.sv
// Queue packet reader: pops one length entry (beats-1), then exactly that many
// data beats, and presents them as a valid/ready stream with first/last framing.
//   clk, i_reset : clock, synchronous active-high reset
//   bus (master) : length/data FIFO read ports and the output beat stream
//   o_busy       : a packet is in progress (FSM not in IDLE)
// Optional build macro QUEUE_PACKET_READER_STATS_EN adds o_pkt_count and
// o_beat_count (wrapping transfer counters cleared by i_reset).
module queue_packet_reader
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = LEN_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 i_reset,
  queue_packet_reader_if.master bus,
  output logic                 o_busy
`ifdef QUEUE_PACKET_READER_STATS_EN
  ,
  output logic [STATS_W-1:0]   o_pkt_count,
  output logic [STATS_W-1:0]   o_beat_count
`endif
);

  localparam int PW = DATA_WIDTH + 2;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d, out_cnt_q, out_cnt_d;
  logic             issue_done_q, issue_done_d;
  logic             issue_first_q, issue_first_d;
  logic             inflight_q, inflight_d;
  logic             inflight_first_q, inflight_first_d;
  logic             inflight_last_q, inflight_last_d;

  logic             sb_valid;
  logic [PW-1:0]    sb_payload;
  logic [1:0]       sb_count;
  logic             fire, pop_len, pop_dat;
  logic [2:0]       level;

  queue_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk         (clk),
    .i_reset     (i_reset),
    .in_valid    (inflight_q),
    .in_payload  ({bus.dat_rd_data, inflight_first_q, inflight_last_q}),
    .out_valid   (sb_valid),
    .out_payload (sb_payload),
    .out_ready   (bus.i_ready),
    .count       (sb_count)
  );

  assign fire = sb_valid && bus.i_ready;

  // Occupancy after this cycle's transfer; counting the outgoing beat as
  // already gone is what allows one pop per cycle while still never holding
  // more than two beats between FIFO and output.
  assign level = 3'(inflight_q) + 3'(sb_count) - 3'(fire);

  // Both pops are gated by reset so nothing leaves a FIFO during the reset cycle.
  assign pop_len = !i_reset && (state_q == IDLE) && !bus.len_empty;
  assign pop_dat = !i_reset && (state_q == STREAM) && !bus.dat_empty
                   && !issue_done_q && (level < 3'd2);

  assign bus.len_rd_en = pop_len;
  assign bus.dat_rd_en = pop_dat;
  assign bus.o_valid   = sb_valid;
  assign bus.o_data    = sb_payload[PW-1:2];
  assign bus.o_first   = sb_valid && sb_payload[1];
  assign bus.o_last    = sb_valid && sb_payload[0];
  assign o_busy        = (state_q != IDLE);

  // Issue side tags each popped beat with its framing so the skid buffer can
  // carry first/last alongside the data; the output side counts transfers
  // and leaves the packet when the last beat is accepted.
  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    out_cnt_d        = out_cnt_q;
    issue_done_d     = issue_done_q;
    issue_first_d    = issue_first_q;
    inflight_d       = pop_dat;
    inflight_first_d = issue_first_q;
    inflight_last_d  = (issue_cnt_q == '0);
    case (state_q)
      IDLE: begin
        if (pop_len) state_d = LEN;
      end
      LEN: begin
        issue_cnt_d   = bus.len_rd_data;
        out_cnt_d     = bus.len_rd_data;
        issue_done_d  = 1'b0;
        issue_first_d = 1'b1;
        state_d       = STREAM;
      end
      STREAM: begin
        if (pop_dat) begin
          issue_first_d = 1'b0;
          if (issue_cnt_q == '0) issue_done_d = 1'b1;
          else                   issue_cnt_d  = issue_cnt_q - LEN_W'(1);
        end
        if (fire) begin
          if (out_cnt_q == '0) state_d   = IDLE;
          else                 out_cnt_d = out_cnt_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q          <= IDLE;
      issue_cnt_q      <= '0;
      out_cnt_q        <= '0;
      issue_done_q     <= 1'b0;
      issue_first_q    <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_first_q <= 1'b0;
      inflight_last_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      issue_cnt_q      <= issue_cnt_d;
      out_cnt_q        <= out_cnt_d;
      issue_done_q     <= issue_done_d;
      issue_first_q    <= issue_first_d;
      inflight_q       <= inflight_d;
      inflight_first_q <= inflight_first_d;
      inflight_last_q  <= inflight_last_d;
    end
  end

`ifdef QUEUE_PACKET_READER_STATS_EN
  logic [STATS_W-1:0] pkt_count_q, pkt_count_d, beat_count_q, beat_count_d;

  // Counters wrap naturally at 2^STATS_W.
  always_comb begin
    pkt_count_d  = pkt_count_q;
    beat_count_d = beat_count_q;
    if (fire) begin
      beat_count_d = beat_count_q + STATS_W'(1);
      if (sb_payload[0]) pkt_count_d = pkt_count_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      pkt_count_q  <= '0;
      beat_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign o_pkt_count  = pkt_count_q;
  assign o_beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_queue_packet_reader.sv
`timescale 1ns/1ps
module tb_queue_packet_reader;

  localparam int DW = 8;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic i_reset;
  logic o_busy;
`ifdef QUEUE_PACKET_READER_STATS_EN
  logic [31:0] o_pkt_count;
  logic [31:0] o_beat_count;
`endif

  queue_packet_reader_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

  queue_packet_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .bus          (bus),
    .o_busy       (o_busy)
`ifdef QUEUE_PACKET_READER_STATS_EN
    ,
    .o_pkt_count  (o_pkt_count),
    .o_beat_count (o_beat_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFOs and expected-beat list, indexed by push/pop counters.
  logic [LW-1:0]   len_mem [0:63];
  logic [DW-1:0]   dat_mem [0:4095];
  logic [DW+1:0]   exp_mem [0:4095];
  int len_pushed = 0, len_popped = 0;
  int dat_pushed = 0, dat_popped = 0;
  int exp_wr = 0, exp_rd = 0;
  int total = 0, bad = 0, cyc = 0, beats_seen = 0;
  int first_cyc = 0, last_cyc = 0;
  logic [DW-1:0] last_data = '0;
  int tgt, p0, lat;
  logic found;

  assign bus.len_empty = (len_pushed == len_popped);
  assign bus.dat_empty = (dat_pushed == dat_popped);

  // FIFO read ports: head appears the cycle after a pop; reset empties both.
  always @(posedge clk) begin
    if (i_reset) begin
      len_popped      <= len_pushed;
      dat_popped      <= dat_pushed;
      bus.len_rd_data <= '0;
      bus.dat_rd_data <= '0;
    end else begin
      if (bus.len_rd_en && (len_popped < len_pushed)) begin
        bus.len_rd_data <= len_mem[len_popped];
        len_popped      <= len_popped + 1;
      end
      if (bus.dat_rd_en && (dat_popped < dat_pushed)) begin
        bus.dat_rd_data <= dat_mem[dat_popped];
        dat_popped      <= dat_popped + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Queue one packet of len+1 beats with data base, base+1, ... (mod 256).
  task automatic applyStimulus(input int len, input int base, input bit preload);
    logic [DW-1:0] v;
    len_mem[len_pushed] = LW'(len);
    len_pushed++;
    for (int k = 0; k <= len; k++) begin
      v = DW'(base + k);
      if (preload) begin
        dat_mem[dat_pushed] = v;
        dat_pushed++;
      end
      exp_mem[exp_wr] = {v, (k == 0), (k == len)};
      exp_wr++;
    end
  endtask

  task automatic pushDat(input logic [DW-1:0] v);
    dat_mem[dat_pushed] = v;
    dat_pushed++;
  endtask

  task automatic waitBeats(input int target, input int budget, input string name);
    for (int i = 0; i < budget && beats_seen < target; i++) @(posedge clk);
    #1;
    checkOutput(name, 32'(beats_seen >= target), 32'd1);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_valid"}, 32'(bus.o_valid), 32'd0);
    checkOutput({name, "_first"}, 32'(bus.o_first), 32'd0);
    checkOutput({name, "_last"},  32'(bus.o_last),  32'd0);
    checkOutput({name, "_data"},  32'(bus.o_data),  32'd0);
    checkOutput({name, "_busy"},  32'(o_busy),      32'd0);
    checkOutput({name, "_lenrd"}, 32'(bus.len_rd_en), 32'd0);
    checkOutput({name, "_datrd"}, 32'(bus.dat_rd_en), 32'd0);
  endtask

  initial begin
    i_reset     = 1'b1;
    bus.i_ready = 1'b1;

    // Per-cycle scoreboard: every valid beat must match the head of the
    // expected list; pops must respect FSM phase and FIFO emptiness.
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (i_reset) begin
          exp_rd = exp_wr;
        end else begin
          if (bus.o_valid) begin
            if (exp_rd < exp_wr) begin
              checkOutput("beat", {22'd0, bus.o_data, bus.o_first, bus.o_last}, {22'd0, exp_mem[exp_rd]});
              if (bus.i_ready) begin
                if (bus.o_first) first_cyc = cyc;
                if (bus.o_last) begin
                  last_cyc  = cyc;
                  last_data = bus.o_data;
                end
                exp_rd++;
                beats_seen++;
              end
            end else begin
              checkOutput("spurious_valid", 32'(bus.o_valid), 32'd0);
            end
          end
          checkOutput("len_pop_busy",  32'(bus.len_rd_en & o_busy), 32'd0);
          checkOutput("len_pop_empty", 32'(bus.len_rd_en & bus.len_empty), 32'd0);
          checkOutput("dat_pop_idle",  32'(bus.dat_rd_en & !o_busy), 32'd0);
          checkOutput("dat_pop_empty", 32'(bus.dat_rd_en & bus.dat_empty), 32'd0);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 i_reset = 1'b0;

    // Lengths {0,3}, ready high: latency and single-beat framing.
    applyStimulus(0, 8'hA0, 1'b1);
    applyStimulus(3, 8'hB0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.len_rd_en;
    end
    checkOutput("t1_len_pop_seen", 32'(found), 32'd1);
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      lat++;
      found = bus.o_valid;
    end
    checkOutput("t1_latency", 32'(lat), 32'd4);
    checkOutput("t1_first_beat", {22'd0, bus.o_data, bus.o_first, bus.o_last}, {22'd0, 8'hA0, 1'b1, 1'b1});
    waitBeats(5, 60, "t1_beats");
    checkOutput("t1_last_data", 32'(last_data), 32'h0000_00B3);

    // Length 7 with ready toggling every cycle.
    p0  = dat_popped;
    tgt = beats_seen + 8;
    applyStimulus(7, 8'h10, 1'b1);
    for (int i = 0; i < 200 && beats_seen < tgt; i++) begin
      @(posedge clk);
      #1 bus.i_ready = ~bus.i_ready;
    end
    checkOutput("t2_beats", 32'(beats_seen >= tgt), 32'd1);
    bus.i_ready = 1'b1;
    checkOutput("t2_dat_pops", 32'(dat_popped - p0), 32'd8);
    checkOutput("t2_last_data", 32'(last_data), 32'h0000_0017);

    // Length 15 with one data beat arriving every third cycle.
    tgt = beats_seen + 16;
    applyStimulus(15, 8'h40, 1'b0);
    for (int k = 0; k < 16; k++) begin
      pushDat(DW'(8'h40 + k));
      repeat (3) @(posedge clk);
      #1;
    end
    waitBeats(tgt, 100, "t3_beats");
    checkOutput("t3_last_data", 32'(last_data), 32'h0000_004F);

    // Maximum length: 2048 back-to-back beats.
    tgt = beats_seen + 2048;
    applyStimulus(2047, 0, 1'b1);
    waitBeats(tgt, 3000, "t4_beats");
    checkOutput("t4_back_to_back", 32'(last_cyc - first_cyc), 32'd2047);
    checkOutput("t4_last_data", 32'(last_data), 32'h0000_00FF);
    @(negedge clk);
    checkOutput("t4_idle", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;

    // Reset two beats into a 10-beat packet, then a fresh 2-beat packet.
    tgt = beats_seen + 2;
    applyStimulus(9, 8'h60, 1'b1);
    for (int i = 0; i < 100 && beats_seen < tgt; i++) @(posedge clk);
    checkOutput("t5_two_beats", 32'(beats_seen >= tgt), 32'd1);
    #1;
    bus.i_ready = 1'b0;
    i_reset     = 1'b1;
    @(posedge clk);
    #1;
    i_reset     = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    checkAllZero("t5_after_reset");
    repeat (2) begin
      @(negedge clk);
      checkOutput("t5_no_pop", 32'({bus.len_rd_en, bus.dat_rd_en, bus.o_valid}), 32'd0);
    end
    @(posedge clk);
    #1;
    tgt = beats_seen + 2;
    applyStimulus(1, 8'h70, 1'b1);
    waitBeats(tgt, 60, "t5_fresh_packet");
    checkOutput("t5_fresh_last", 32'(last_data), 32'h0000_0071);

`ifdef QUEUE_PACKET_READER_STATS_EN
    // Packets of 1, 5 and 10 beats after a reset: 3 packets, 16 beats.
    @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    checkOutput("stats_pkt_reset",  o_pkt_count,  32'd0);
    checkOutput("stats_beat_reset", o_beat_count, 32'd0);
    tgt = beats_seen + 16;
    applyStimulus(0, 8'h80, 1'b1);
    applyStimulus(4, 8'h90, 1'b1);
    applyStimulus(9, 8'hC0, 1'b1);
    waitBeats(tgt, 200, "stats_beats");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stats_pkt",  o_pkt_count,  32'd3);
    checkOutput("stats_beat", o_beat_count, 32'd16);
`endif

    repeat (5) @(posedge clk);
    #1;
    checkOutput("all_delivered", 32'(exp_rd), 32'(exp_wr));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
